// File: rtl/noc_ring_pkg.sv
// Shared constants for the ring NIC host controller.
// The NIC numbers its 64-bit words [0:63] with bit 0 as the MSB; here bit i sits at [63-i].
package noc_ring_pkg;

   localparam logic [1:0] NIC_IN_BUF   = 2'b00;
   localparam logic [1:0] NIC_IN_STAT  = 2'b01;
   localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
   localparam logic [1:0] NIC_OUT_STAT = 2'b11;

   localparam int PKT_VC_BIT    = 63;
   localparam int PKT_DIR_BIT   = 62;
   localparam int PKT_HOP_HI    = 55;
   localparam int PKT_HOP_LO    = 48;
   localparam int PKT_SRC_HI    = 47;
   localparam int PKT_SRC_LO    = 32;
   localparam int PKT_DATA_HI   = 31;
   localparam int PKT_DATA_LO   = 0;
   localparam int STAT_FLAG_BIT = 0;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      TX_POLL = 4'd1,
      TX_CHK  = 4'd2,
      TX_WR   = 4'd3,
      RX_POLL = 4'd4,
      RX_CHK  = 4'd5,
      RX_RD   = 4'd6,
      RX_CAP  = 4'd7,
      RX_HOLD = 4'd8
   } state_t;

   typedef enum logic {
      GRANT_RX = 1'b0,
      GRANT_TX = 1'b1
   } grant_t;

endpackage

// File: rtl/nic_pkt_fmt.sv
// Combinational packet header formation: virtual channel, ring direction and hop
// count from the destination's distance around the 4-node ring.
module nic_pkt_fmt
   import noc_ring_pkg::*;
#(
   parameter int unsigned NODE_ID = 0
) (
   input  logic [1:0]  dest,
   input  logic [31:0] data,
   output logic [63:0] pkt
);

   localparam logic [1:0] NODE = NODE_ID[1:0];

   logic [1:0] delta;
   logic       dir;
   logic [7:0] hop;

   assign delta = dest - NODE;

   always_comb begin
      dir = 1'b0;
      hop = 8'h00;
      case (delta)
         2'd1: hop = 8'h01;
         2'd2: hop = 8'h03;
         2'd3: begin
            dir = 1'b1;
            hop = 8'h01;
         end
         default: ;
      endcase

      pkt                            = '0;
      pkt[PKT_VC_BIT]                = NODE[1];
      pkt[PKT_DIR_BIT]               = dir;
      pkt[PKT_HOP_HI:PKT_HOP_LO]     = hop;
      pkt[PKT_SRC_HI:PKT_SRC_LO]     = {14'd0, NODE};
      pkt[PKT_DATA_HI:PKT_DATA_LO]   = data;
   end

endmodule

// File: rtl/nic_host_ctrl.sv
// Host-side controller for a ring NIC: alternates send and receive polling.
// Optional NIC_CTRL_STATS_EN adds tx_count/rx_count traffic counters.
//
// state   | meaning
// IDLE    | arbitrate between send and receive, drop self-addressed requests
// TX_POLL | read output status
// TX_CHK  | output buffer free? write it, else give up this round
// TX_WR   | write packet to output buffer, accept request
// RX_POLL | read input status
// RX_CHK  | input packet waiting? read it, else back to IDLE
// RX_RD   | read input buffer
// RX_CAP  | capture read data into rx_data
// RX_HOLD | present rx_data until the host takes it
module nic_host_ctrl
   import noc_ring_pkg::*;
#(
   parameter int unsigned NODE_ID = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [1:0]  tx_dest,
   input  logic [31:0] tx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [63:0] rx_data,
   output logic [1:0]  nic_addr,
   output logic [63:0] nic_d_in,
   input  logic [63:0] nic_d_out,
   output logic        nic_en,
   output logic        nic_wr_en,
   output logic        tx_err
`ifdef NIC_CTRL_STATS_EN
   ,
   output logic [15:0] tx_count,
   output logic [15:0] rx_count
`endif
);

   localparam logic [1:0] NODE = NODE_ID[1:0];

   state_t      state, state_nxt;
   grant_t      last_grant, grant_nxt;
   logic [63:0] pkt;
   logic        self_dest;

   nic_pkt_fmt #(.NODE_ID(NODE_ID)) u_fmt (
      .dest (tx_dest),
      .data (tx_data),
      .pkt  (pkt)
   );

   assign self_dest = tx_valid && (tx_dest == NODE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= GRANT_RX;
         rx_data    <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= grant_nxt;
         if (state == RX_CAP) rx_data <= nic_d_out;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = last_grant;
      tx_ready  = 1'b0;
      tx_err    = 1'b0;
      rx_valid  = 1'b0;
      nic_addr  = 2'b00;
      nic_en    = 1'b0;
      nic_wr_en = 1'b0;
      nic_d_in  = '0;
      case (state)
         IDLE: begin
            // IDLE is also the reset state, so the drop pulse is qualified by reset.
            if (self_dest) begin
               tx_err   = reset;
               tx_ready = reset;
            end else begin
               grant_nxt = (last_grant == GRANT_RX) ? GRANT_TX : GRANT_RX;
               state_nxt = (tx_valid && last_grant == GRANT_RX) ? TX_POLL : RX_POLL;
            end
         end
         TX_POLL: begin
            nic_addr  = NIC_OUT_STAT;
            nic_en    = 1'b1;
            state_nxt = TX_CHK;
         end
         TX_CHK: begin
            state_nxt = (nic_d_out == '0) ? TX_WR : IDLE;
         end
         TX_WR: begin
            if (tx_valid) begin
               nic_addr  = NIC_OUT_BUF;
               nic_en    = 1'b1;
               nic_wr_en = 1'b1;
               nic_d_in  = pkt;
               tx_ready  = 1'b1;
            end
            state_nxt = IDLE;
         end
         RX_POLL: begin
            nic_addr  = NIC_IN_STAT;
            nic_en    = 1'b1;
            state_nxt = RX_CHK;
         end
         RX_CHK: begin
            state_nxt = nic_d_out[STAT_FLAG_BIT] ? RX_RD : IDLE;
         end
         RX_RD: begin
            nic_addr  = NIC_IN_BUF;
            nic_en    = 1'b1;
            state_nxt = RX_CAP;
         end
         RX_CAP: begin
            state_nxt = RX_HOLD;
         end
         RX_HOLD: begin
            rx_valid = 1'b1;
            if (rx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef NIC_CTRL_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_count <= '0;
         rx_count <= '0;
      end else begin
         if (state == TX_WR && tx_valid) tx_count <= tx_count + 16'd1;
         if (state == RX_HOLD && rx_ready) rx_count <= rx_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nic_host_ctrl.sv
// Self-checking bench for nic_host_ctrl: node 1 against a small NIC model,
// node 2 alongside for header formation.
module tb_nic_host_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        tx_valid;
   logic [1:0]  tx_dest;
   logic [31:0] tx_data;
   logic        rx_ready;

   logic        tx_ready, rx_valid, nic_en, nic_wr_en, tx_err;
   logic [63:0] rx_data, nic_d_in, nic_d_out;
   logic [1:0]  nic_addr;

   logic        tx_ready2, rx_valid2, nic_en2, nic_wr_en2, tx_err2;
   logic [63:0] rx_data2, nic_d_in2, nic_d_out2;
   logic [1:0]  nic_addr2;
`ifdef NIC_CTRL_STATS_EN
   logic [15:0] tx_count, rx_count, tx_count2, rx_count2;
`endif

   assign nic_d_out2 = '0;

   nic_host_ctrl #(.NODE_ID(1)) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
      .nic_en(nic_en), .nic_wr_en(nic_wr_en), .tx_err(tx_err)
`ifdef NIC_CTRL_STATS_EN
      , .tx_count(tx_count), .rx_count(rx_count)
`endif
   );

   nic_host_ctrl #(.NODE_ID(2)) dut2 (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_ready(tx_ready2), .tx_dest(tx_dest), .tx_data(tx_data),
      .rx_valid(rx_valid2), .rx_ready(rx_ready), .rx_data(rx_data2),
      .nic_addr(nic_addr2), .nic_d_in(nic_d_in2), .nic_d_out(nic_d_out2),
      .nic_en(nic_en2), .nic_wr_en(nic_wr_en2), .tx_err(tx_err2)
`ifdef NIC_CTRL_STATS_EN
      , .tx_count(tx_count2), .rx_count(rx_count2)
`endif
   );

   // NIC model for node 1: registered reads, logged writes, access counter.
   logic [63:0] out_stat, in_stat, in_buf, rd_mux, wr_data;
   logic [1:0]  wr_addr;
   int          wr_count = 0;
   int          acc_count = 0;

   always_comb begin
      rd_mux = '0;
      case (nic_addr)
         2'b00:   rd_mux = in_buf;
         2'b01:   rd_mux = in_stat;
         2'b11:   rd_mux = out_stat;
         default: rd_mux = '0;
      endcase
   end

   always @(posedge clk) begin
      nic_d_out <= (nic_en && !nic_wr_en) ? rd_mux : '0;
      if (nic_en) acc_count <= acc_count + 1;
      if (nic_en && nic_wr_en) begin
         wr_count <= wr_count + 1;
         wr_data  <= nic_d_in;
         wr_addr  <= nic_addr;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  dest;
      logic [31:0] data;
      logic        err1;
      logic [63:0] pkt1;
      logic        err2;
      logic [63:0] pkt2;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      int wc0, a0, lat, bad, polls;
      logic seen;

      vecs[0] = '{2'd2, 32'hDEADBEEF, 1'b0, 64'h00010001DEADBEEF, 1'b1, 64'h0};
      vecs[1] = '{2'd0, 32'hDEADBEEF, 1'b0, 64'h40010001DEADBEEF, 1'b0, 64'h80030002DEADBEEF};
      vecs[2] = '{2'd3, 32'hDEADBEEF, 1'b0, 64'h00030001DEADBEEF, 1'b0, 64'h80010002DEADBEEF};
      vecs[3] = '{2'd1, 32'h12345678, 1'b1, 64'h0, 1'b0, 64'hC001000212345678};

      reset = 1'b0; tx_valid = 1'b1; tx_dest = 2'd1; tx_data = '0; rx_ready = 1'b0;
      out_stat = '0; in_stat = '0; in_buf = '0;
      tick();
      tick();
      check("reset_outs1", {tx_ready, rx_valid, nic_en, nic_wr_en, tx_err, nic_addr, nic_d_in, rx_data}, '0);
      check("reset_outs2", {tx_ready2, rx_valid2, nic_en2, nic_wr_en2, tx_err2, nic_addr2, nic_d_in2, rx_data2}, '0);

      // Header table: both nodes start from IDLE, status free, write lands on cycle 3.
      for (int i = 0; i < 4; i++) begin
         tx_valid = 1'b0;
         do_reset();
         wc0 = wr_count;
         tx_dest = vecs[i].dest; tx_data = vecs[i].data; tx_valid = 1'b1;
         #1;
         check($sformatf("v%0d_err1", i), tx_err, vecs[i].err1);
         check($sformatf("v%0d_err2", i), tx_err2, vecs[i].err2);
         tick(); tick(); tick();
         check($sformatf("v%0d_wr1", i), {nic_en, nic_wr_en, nic_d_in},
               vecs[i].err1 ? 66'h0 : {2'b11, vecs[i].pkt1});
         check($sformatf("v%0d_wr2", i), {nic_en2, nic_wr_en2, nic_d_in2},
               vecs[i].err2 ? 66'h0 : {2'b11, vecs[i].pkt2});
         check($sformatf("v%0d_ready1", i), tx_ready, 1'b1);
         tick();
         tx_valid = 1'b0;
         check($sformatf("v%0d_wcount", i), wr_count - wc0, vecs[i].err1 ? 0 : 1);
      end

      // Output buffer busy: no write, one RX poll in between, then the retry writes.
      tx_valid = 1'b0;
      out_stat = 64'h1; in_stat = '0;
      do_reset();
      wc0 = wr_count;
      tx_dest = 2'd2; tx_data = 32'hDEADBEEF; tx_valid = 1'b1;
      tick();
      check("busy_poll", {nic_addr, nic_en, nic_wr_en}, {2'b11, 1'b1, 1'b0});
      tick();
      check("busy_chk_ready", tx_ready, 1'b0);
      out_stat = '0;
      bad = 0; polls = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (tx_ready) bad++;
         if (nic_en && nic_addr == 2'b01) polls++;
      end
      check("busy_no_ready", bad, 0);
      check("busy_rx_polls", polls, 1);
      check("busy_no_write", wr_count - wc0, 0);
      tick();
      check("retry_write", {nic_addr, nic_en, nic_wr_en, tx_ready, nic_d_in},
            {2'b10, 1'b1, 1'b1, 1'b1, 64'h00010001DEADBEEF});
      tick();
      tx_valid = 1'b0;
      check("retry_logged", {wr_count - wc0, wr_addr, wr_data}, {32'd1, 2'b10, 64'h00010001DEADBEEF});
`ifdef NIC_CTRL_STATS_EN
      check("tx_count", tx_count, 16'd1);
`endif

      // Receive with the host stalling for 5 cycles.
      in_stat = 64'h1; in_buf = 64'h2; out_stat = '0;
      do_reset();
      lat = 0; seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         lat++;
         seen = rx_valid;
      end
      check("rx_latency", lat, 5);
      check("rx_data", {rx_valid, rx_data}, {1'b1, 64'h2});
      in_stat = '0;
      a0 = acc_count; bad = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (!rx_valid || rx_data != 64'h2 || nic_en) bad++;
      end
      check("rx_hold_stable", bad, 0);
      check("rx_hold_no_access", acc_count - a0, 0);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("rx_released", rx_valid, 1'b0);
`ifdef NIC_CTRL_STATS_EN
      check("rx_count", rx_count, 16'd1);
`endif

      // Self-addressed request on node 1.
      do_reset();
      wc0 = wr_count;
      tx_dest = 2'd1; tx_data = 32'hCAFEF00D; tx_valid = 1'b1;
      #1;
      check("self_pulse", {tx_err, tx_ready, nic_en}, 3'b110);
      tick();
      tx_valid = 1'b0;
      #1;
      check("self_pulse_end", {tx_err, tx_ready}, 2'b00);
      for (int c = 0; c < 4; c++) tick();
      check("self_no_write", wr_count - wc0, 0);

      // Reset while holding a received packet.
      in_stat = 64'h1; in_buf = 64'hA5A5_0000_1234_5678;
      do_reset();
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         seen = rx_valid;
      end
      check("hold_reached", {rx_valid, rx_data}, {1'b1, 64'hA5A5_0000_1234_5678});
      #2;
      reset = 1'b0;
      #1;
      check("midreset_outs", {rx_valid, nic_en, rx_data}, '0);
`ifdef NIC_CTRL_STATS_EN
      check("midreset_counts", {tx_count, rx_count}, '0);
`endif
      in_stat = '0;
      tick();
      reset = 1'b1;
      tx_dest = 2'd2; tx_valid = 1'b1;
      tick();
      check("post_reset_idle", {nic_addr, nic_en, nic_wr_en}, {2'b11, 1'b1, 1'b0});
      tx_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
